// File: rtl/dispense_controller_if.sv
// Front-panel / sensor / valve signal bundle of the water dispenser controller.
// The master side drives buttons and sensors; the slave side is the controller.
interface dispense_controller_if #(
    parameter int COUNT_WIDTH = 28
);
    logic                   select_pressed;
    logic                   start_pressed;
    logic                   cancel_pressed;
    logic                   cup_present;
    logic                   water_low;
    logic                   valve_open;
    logic [1:0]             selected_size;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   busy;
    logic                   done;
    logic                   fault;
    logic [2:0]             state;

    modport master (
        output select_pressed, start_pressed, cancel_pressed, cup_present, water_low,
        input  valve_open, selected_size, remaining, busy, done, fault, state
    );

    modport slave (
        input  select_pressed, start_pressed, cancel_pressed, cup_present, water_low,
        output valve_open, selected_size, remaining, busy, done, fault, state
    );
endinterface

// File: rtl/dispense_controller.sv
// Main sequencing FSM of the water dispenser: size selection, timed valve dose
// with pause/resume on cup removal, cancel, low-water fault and a timed done phase.
module dispense_controller #(
    parameter int COUNT_WIDTH     = 28,
    parameter int SMALL_TICKS     = 100000000,
    parameter int MEDIUM_TICKS    = 200000000,
    parameter int LARGE_TICKS     = 250000000,
    parameter int DONE_HOLD_TICKS = 50000000
) (
    input  logic                        clock,
    input  logic                        reset,
    dispense_controller_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DISPENSING = 3'd1,
        S_PAUSED     = 3'd2,
        S_DONE       = 3'd3,
        S_FAULT      = 3'd4
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] SMALL_C  = COUNT_WIDTH'(SMALL_TICKS);
    localparam logic [COUNT_WIDTH-1:0] MEDIUM_C = COUNT_WIDTH'(MEDIUM_TICKS);
    localparam logic [COUNT_WIDTH-1:0] LARGE_C  = COUNT_WIDTH'(LARGE_TICKS);
    localparam logic [COUNT_WIDTH-1:0] HOLD_C   = COUNT_WIDTH'(DONE_HOLD_TICKS);
    localparam logic [COUNT_WIDTH-1:0] ONE_C    = COUNT_WIDTH'(1);

    state_t                 state_q, state_n;
    logic [1:0]             size_q, size_n;
    logic [COUNT_WIDTH-1:0] rem_q, rem_n;
    logic [COUNT_WIDTH-1:0] hold_q, hold_n;
    logic [COUNT_WIDTH-1:0] dose_ticks;
    logic                   valve_q, busy_q, done_q, fault_q;

    always_comb begin
        case (size_q)
            2'd1:    dose_ticks = MEDIUM_C;
            2'd2:    dose_ticks = LARGE_C;
            default: dose_ticks = SMALL_C;
        endcase
    end

    // Next-state logic; in DISPENSING the if-chain order is the event priority
    always_comb begin
        state_n = state_q;
        size_n  = size_q;
        rem_n   = rem_q;
        hold_n  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (bus.select_pressed)
                    size_n = (size_q == 2'd2) ? 2'd0 : size_q + 2'd1;
                if (bus.start_pressed) begin
                    if (bus.water_low) begin
                        state_n = S_FAULT;
                    end else if (bus.cup_present) begin
                        rem_n   = dose_ticks;
                        state_n = S_DISPENSING;
                    end
                end
            end
            S_DISPENSING: begin
                if (bus.cancel_pressed) begin
                    rem_n   = '0;
                    state_n = S_IDLE;
                end else if (bus.water_low) begin
                    state_n = S_FAULT;
                end else if (rem_q == ONE_C) begin
                    rem_n   = '0;
                    hold_n  = HOLD_C;
                    state_n = S_DONE;
                end else begin
                    rem_n = rem_q - ONE_C;
                    if (!bus.cup_present)
                        state_n = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (bus.cancel_pressed) begin
                    rem_n   = '0;
                    state_n = S_IDLE;
                end else if (bus.water_low) begin
                    state_n = S_FAULT;
                end else if (bus.start_pressed && bus.cup_present) begin
                    state_n = S_DISPENSING;
                end
            end
            S_DONE: begin
                if (hold_q <= ONE_C) begin
                    hold_n  = '0;
                    state_n = S_IDLE;
                end else begin
                    hold_n = hold_q - ONE_C;
                end
            end
            S_FAULT: begin
                if (bus.cancel_pressed && !bus.water_low) begin
                    rem_n   = '0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                rem_n   = '0;
                hold_n  = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they move with state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            size_q  <= 2'd0;
            rem_q   <= '0;
            hold_q  <= '0;
            valve_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_n;
            size_q  <= size_n;
            rem_q   <= rem_n;
            hold_q  <= hold_n;
            valve_q <= (state_n == S_DISPENSING);
            busy_q  <= (state_n == S_DISPENSING) || (state_n == S_PAUSED);
            done_q  <= (state_n == S_DONE);
            fault_q <= (state_n == S_FAULT);
        end
    end

    assign bus.valve_open    = valve_q;
    assign bus.selected_size = size_q;
    assign bus.remaining     = rem_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.fault         = fault_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_dispense_controller.sv
// Self-checking bench for dispense_controller: directed scenarios followed by
// random button/sensor traffic, compared cycle by cycle with a rule-level model.
module tb_dispense_controller;
    localparam int CW     = 8;
    localparam int SMALL  = 5;
    localparam int MEDIUM = 8;
    localparam int LARGE  = 12;
    localparam int HOLD   = 3;

    logic clock = 1'b0;
    logic reset;

    dispense_controller_if #(.COUNT_WIDTH(CW)) dif ();

    dispense_controller #(
        .COUNT_WIDTH     (CW),
        .SMALL_TICKS     (SMALL),
        .MEDIUM_TICKS    (MEDIUM),
        .LARGE_TICKS     (LARGE),
        .DONE_HOLD_TICKS (HOLD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif.slave)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Model: 0 idle, 1 dispensing, 2 paused, 3 done, 4 fault
    int m_state, m_size, m_rem, m_hold;
    int dose_size, open_seen;
    bit dose_finished;

    function automatic int ticks(input int s);
        return (s == 0) ? SMALL : (s == 1) ? MEDIUM : LARGE;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_size  = 0;
        m_rem   = 0;
        m_hold  = 0;
    endtask

    task automatic model_step(input bit sel, input bit start, input bit cancel,
                              input bit cup, input bit low);
        int old_size;
        dose_finished = 1'b0;
        if (m_state == 0) begin
            old_size = m_size;
            if (sel) m_size = (m_size + 1) % 3;
            if (start && low) begin
                m_state = 4;
            end else if (start && cup) begin
                m_rem     = ticks(old_size);
                dose_size = old_size;
                open_seen = 0;
                m_state   = 1;
            end
        end else if (m_state == 1) begin
            if (cancel) begin
                m_state = 0;
                m_rem   = 0;
            end else if (low) begin
                m_state = 4;
            end else if (m_rem == 1) begin
                m_state       = 3;
                m_rem         = 0;
                m_hold        = HOLD;
                dose_finished = 1'b1;
            end else begin
                m_rem = m_rem - 1;
                if (!cup) m_state = 2;
            end
        end else if (m_state == 2) begin
            if (cancel) begin
                m_state = 0;
                m_rem   = 0;
            end else if (low) begin
                m_state = 4;
            end else if (start && cup) begin
                m_state = 1;
            end
        end else if (m_state == 3) begin
            if (m_hold == 1) m_state = 0;
            m_hold = m_hold - 1;
        end else begin
            if (cancel && !low) begin
                m_state = 0;
                m_rem   = 0;
            end
        end
    endtask

    task automatic check_output();
        check_eq("state", dif.state, m_state);
        check_eq("valve_open", dif.valve_open, m_state == 1);
        check_eq("selected_size", dif.selected_size, m_size);
        check_eq("remaining", dif.remaining, m_rem);
        check_eq("busy", dif.busy, (m_state == 1) || (m_state == 2));
        check_eq("done", dif.done, m_state == 3);
        check_eq("fault", dif.fault, m_state == 4);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check
    task automatic apply_stimulus(input bit sel, input bit start, input bit cancel,
                                  input bit cup, input bit low);
        dif.select_pressed = sel;
        dif.start_pressed  = start;
        dif.cancel_pressed = cancel;
        dif.cup_present    = cup;
        dif.water_low      = low;
        @(posedge clock);
        model_step(sel, start, cancel, cup, low);
        #1;
        check_output();
        if (dif.valve_open === 1'b1) open_seen++;
        if (dose_finished) check_eq("open_total", open_seen, ticks(dose_size));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 1, 0);
    endtask

    initial begin
        bit low_level;
        reset              = 1'b1;
        dif.select_pressed = 1'b0;
        dif.start_pressed  = 1'b0;
        dif.cancel_pressed = 1'b0;
        dif.cup_present    = 1'b1;
        dif.water_low      = 1'b0;
        dose_size          = 0;
        open_seen          = 0;
        model_reset();
        #12;
        check_output();
        reset = 1'b0;

        $display("[TB] plan 1: small dose and done hold");
        apply_stimulus(0, 1, 0, 1, 0);
        check_eq("plan1_first_rem", dif.remaining, SMALL);
        idle_cycles(SMALL + HOLD);
        check_eq("plan1_back_idle", dif.state, 0);

        $display("[TB] plan 2: size cycling and large dose");
        apply_stimulus(1, 0, 0, 1, 0);
        check_eq("plan2_size1", dif.selected_size, 1);
        apply_stimulus(1, 0, 0, 1, 0);
        check_eq("plan2_size2", dif.selected_size, 2);
        apply_stimulus(1, 0, 0, 1, 0);
        check_eq("plan2_size0", dif.selected_size, 0);
        apply_stimulus(1, 0, 0, 1, 0);
        apply_stimulus(1, 0, 0, 1, 0);
        apply_stimulus(0, 1, 0, 1, 0);
        idle_cycles(LARGE + HOLD + 1);

        $display("[TB] plan 3: pause and resume a medium dose");
        apply_stimulus(1, 0, 0, 1, 0);
        apply_stimulus(1, 0, 0, 1, 0);
        apply_stimulus(0, 1, 0, 1, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        check_eq("plan3_paused_rem", dif.remaining, 5);
        check_eq("plan3_paused_valve", dif.valve_open, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 1, 0, 1, 0);
        idle_cycles(5 + HOLD + 1);

        $display("[TB] plan 4: cancel beats water_low");
        apply_stimulus(0, 1, 0, 1, 0);
        idle_cycles(2);
        apply_stimulus(0, 0, 1, 1, 1);
        check_eq("plan4_state", dif.state, 0);
        check_eq("plan4_rem", dif.remaining, 0);
        check_eq("plan4_fault", dif.fault, 0);

        $display("[TB] plan 5: low-water fault and clear");
        apply_stimulus(0, 1, 0, 1, 0);
        idle_cycles(2);
        apply_stimulus(0, 0, 0, 1, 1);
        check_eq("plan5_fault", dif.state, 4);
        apply_stimulus(0, 0, 1, 1, 1);
        check_eq("plan5_stuck", dif.state, 4);
        apply_stimulus(0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 1, 1, 0);
        check_eq("plan5_cleared", dif.state, 0);
        check_eq("plan5_rem", dif.remaining, 0);

        $display("[TB] plan 6: asynchronous reset mid-dose");
        apply_stimulus(0, 1, 0, 1, 0);
        idle_cycles(MEDIUM - 3);
        check_eq("plan6_rem_before", dif.remaining, 3);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_eq("plan6_async_valve", dif.valve_open, 0);
        check_output();
        @(negedge clock);
        reset = 1'b0;
        apply_stimulus(0, 1, 0, 0, 0);
        check_eq("plan6_no_cup", dif.state, 0);

        $display("[TB] random traffic");
        low_level = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) low_level = ~low_level;
            apply_stimulus($urandom_range(0, 7) == 0,
                           $urandom_range(0, 3) == 0,
                           $urandom_range(0, 19) == 0,
                           $urandom_range(0, 9) != 0,
                           low_level);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
